// File: rtl/cp0_exception_controller.sv
// CP0 exception/interrupt sequencer: owns Status/Cause/EPC, arbitrates decode-stage
// events by fixed priority and issues a one-cycle fetch redirect to the handler or EPC.
module cp0_exception_controller #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000F000,
    parameter int          INT_LINES    = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Commit,
    input  logic [31:0]          PC_plus_4,
    input  logic                 Break,
    input  logic                 Syscall,
    input  logic                 Overflow,
    input  logic                 Divide_zero,
    input  logic                 Reserved_instruction,
    input  logic                 Eret,
    input  logic                 Mtc0,
    input  logic                 Mfc0,
    input  logic [4:0]           Cp0_reg,
    input  logic [31:0]          Mtc0_data,
    input  logic [INT_LINES-1:0] Interrupt_in,
    output logic [31:0]          Cp0_read_data,
    output logic                 Redirect,
    output logic [31:0]          Redirect_pc,
    output logic                 Stall,
    output logic [31:0]          Status,
    output logic [31:0]          Cause,
    output logic [31:0]          EPC
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_e;

    state_e                 state_q;
    logic [INT_LINES-1:0]   sync1_q;
    logic [INT_LINES-1:0]   sync2_q;
    logic [31:0]            status_q;
    logic [31:0]            status_d;
    logic [31:0]            epc_q;
    logic [31:0]            epc_d;
    logic [4:0]             exc_code_q;
    logic [4:0]             exc_code_d;
    logic [1:0]             ip_sw_q;
    logic [1:0]             ip_sw_d;
    logic                   redirect_q;
    logic                   stall_q;
    logic [31:0]            redirect_pc_q;

    logic [5:0]             ip_hw_s;
    logic [31:0]            cause_s;
    logic                   idle_commit_s;
    logic                   int_req_s;
    logic                   exc_take_s;
    logic [4:0]             exc_code_s;
    logic                   eret_take_s;
    logic                   mtc0_take_s;

    // Map the synchronized interrupt lines onto the hardware IP field
    always_comb begin
        ip_hw_s = 6'd0;
        for (int i = 0; i < INT_LINES; i++) begin
            ip_hw_s[i] = sync2_q[i];
        end
    end

    assign cause_s       = {16'h0000, ip_hw_s, ip_sw_q, 1'b0, exc_code_q, 2'b00};
    assign idle_commit_s = (state_q == IDLE) && Commit;
    assign int_req_s     = status_q[0] & (|(cause_s[15:8] & status_q[15:8]));

    // Fixed-priority event arbitration; synchronous exceptions ignore IE
    always_comb begin
        exc_take_s = 1'b1;
        exc_code_s = 5'd0;
        if (!idle_commit_s) begin
            exc_take_s = 1'b0;
        end else if (Reserved_instruction) begin
            exc_code_s = 5'd10;
        end else if (Break) begin
            exc_code_s = 5'd9;
        end else if (Syscall) begin
            exc_code_s = 5'd8;
        end else if (Overflow) begin
            exc_code_s = 5'd12;
        end else if (Divide_zero) begin
            exc_code_s = 5'd7;
        end else if (int_req_s) begin
            exc_code_s = 5'd0;
        end else begin
            exc_take_s = 1'b0;
        end
    end

    assign eret_take_s = idle_commit_s & Eret & ~exc_take_s;
    assign mtc0_take_s = idle_commit_s & Mtc0 & ~exc_take_s & ~Eret;

    // Next-state values of the CP0 registers
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        if (exc_take_s) begin
            epc_d       = PC_plus_4;
            exc_code_d  = exc_code_s;
            status_d[0] = 1'b0;
        end else if (eret_take_s) begin
            status_d[0] = 1'b1;
        end else if (mtc0_take_s) begin
            case (Cp0_reg)
                5'd12:   status_d = Mtc0_data;
                5'd13:   ip_sw_d  = Mtc0_data[9:8];
                5'd14:   epc_d    = Mtc0_data;
                default: status_d = status_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // Sequencer state, CP0 registers, synchronizer and registered redirect outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            status_q      <= 32'd0;
            epc_q         <= 32'd0;
            exc_code_q    <= 5'd0;
            ip_sw_q       <= 2'd0;
            redirect_q    <= 1'b0;
            stall_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            sync1_q    <= Interrupt_in;
            sync2_q    <= sync1_q;
            status_q   <= status_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            case (state_q)
                IDLE: begin
                    if (exc_take_s) begin
                        state_q       <= ENTER;
                        redirect_q    <= 1'b1;
                        stall_q       <= 1'b1;
                        redirect_pc_q <= HANDLER_ADDR;
                    end else if (eret_take_s) begin
                        // EPC cannot change while in RETURN, so sample it now
                        state_q       <= RETURN;
                        redirect_q    <= 1'b1;
                        stall_q       <= 1'b1;
                        redirect_pc_q <= epc_q;
                    end else begin
                        state_q       <= IDLE;
                        redirect_q    <= 1'b0;
                        stall_q       <= 1'b0;
                        redirect_pc_q <= 32'd0;
                    end
                end
                ENTER, RETURN: begin
                    state_q       <= IDLE;
                    redirect_q    <= 1'b0;
                    stall_q       <= 1'b0;
                    redirect_pc_q <= 32'd0;
                end
                default: begin
                    state_q       <= IDLE;
                    redirect_q    <= 1'b0;
                    stall_q       <= 1'b0;
                    redirect_pc_q <= 32'd0;
                end
            endcase
        end
    end

    // mfc0 read mux; unmapped registers and idle strobe read all-ones
    always_comb begin
        Cp0_read_data = 32'hFFFFFFFF;
        if (Mfc0) begin
            case (Cp0_reg)
                5'd12:   Cp0_read_data = status_q;
                5'd13:   Cp0_read_data = cause_s;
                5'd14:   Cp0_read_data = epc_q;
                default: Cp0_read_data = 32'hFFFFFFFF;
            endcase
        end else begin
            Cp0_read_data = 32'hFFFFFFFF;
        end
    end

    assign Redirect    = redirect_q;
    assign Stall       = stall_q;
    assign Redirect_pc = redirect_pc_q;
    assign Status      = status_q;
    assign Cause       = cause_s;
    assign EPC         = epc_q;

endmodule

// File: tb/tb_cp0_exception_controller.sv
// Directed self-checking bench for cp0_exception_controller.
module tb_cp0_exception_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        Commit;
    logic [31:0] PC_plus_4;
    logic        Break, Syscall, Overflow, Divide_zero, Reserved_instruction;
    logic        Eret, Mtc0, Mfc0;
    logic [4:0]  Cp0_reg;
    logic [31:0] Mtc0_data;
    logic [5:0]  Interrupt_in;
    logic [31:0] Cp0_read_data;
    logic        Redirect;
    logic [31:0] Redirect_pc;
    logic        Stall;
    logic [31:0] Status, Cause, EPC;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    cp0_exception_controller dut (
        .clock                (clock),
        .reset                (reset),
        .Commit               (Commit),
        .PC_plus_4            (PC_plus_4),
        .Break                (Break),
        .Syscall              (Syscall),
        .Overflow             (Overflow),
        .Divide_zero          (Divide_zero),
        .Reserved_instruction (Reserved_instruction),
        .Eret                 (Eret),
        .Mtc0                 (Mtc0),
        .Mfc0                 (Mfc0),
        .Cp0_reg              (Cp0_reg),
        .Mtc0_data            (Mtc0_data),
        .Interrupt_in         (Interrupt_in),
        .Cp0_read_data        (Cp0_read_data),
        .Redirect             (Redirect),
        .Redirect_pc          (Redirect_pc),
        .Stall                (Stall),
        .Status               (Status),
        .Cause                (Cause),
        .EPC                  (EPC)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        Commit = 1'b0; PC_plus_4 = 32'd0;
        Break = 1'b0; Syscall = 1'b0; Overflow = 1'b0; Divide_zero = 1'b0;
        Reserved_instruction = 1'b0; Eret = 1'b0; Mtc0 = 1'b0; Mfc0 = 1'b0;
        Cp0_reg = 5'd0; Mtc0_data = 32'd0;
    endtask

    task automatic do_mtc0(input logic [4:0] r, input logic [31:0] d);
        Commit = 1'b1; Mtc0 = 1'b1; Cp0_reg = r; Mtc0_data = d;
        tick();
        clear_inputs();
    endtask

    task automatic commit_pc(input logic [31:0] pc);
        Commit = 1'b1; PC_plus_4 = pc;
        tick();
        clear_inputs();
    endtask

    task automatic mfc0_check(input string tag, input logic [4:0] r, input logic [31:0] exp);
        Mfc0 = 1'b1; Cp0_reg = r;
        #1;
        check_eq(tag, Cp0_read_data, exp);
        Mfc0 = 1'b0; Cp0_reg = 5'd0;
    endtask

    initial begin
        reset = 1'b1;
        Interrupt_in = 6'd0;
        clear_inputs();
        tick();
        tick();
        check_eq("rst_status", Status, 32'd0);
        check_eq("rst_cause", Cause, 32'd0);
        check_eq("rst_epc", EPC, 32'd0);
        check_eq("rst_redirect", {31'd0, Redirect}, 32'd0);
        check_eq("rst_stall", {31'd0, Stall}, 32'd0);
        check_eq("rst_rpc", Redirect_pc, 32'd0);
        check_eq("rst_rdata", Cp0_read_data, 32'hFFFFFFFF);
        reset = 1'b0;
        tick();

        // software IP write masks to bits [9:8]; unmapped and idle reads
        do_mtc0(5'd13, 32'hFFFFFFFF);
        mfc0_check("mfc0_cause_sw", 5'd13, 32'h00000300);
        mfc0_check("mfc0_reg5", 5'd5, 32'hFFFFFFFF);
        Cp0_reg = 5'd12; #1;
        check_eq("mfc0_off", Cp0_read_data, 32'hFFFFFFFF);
        Cp0_reg = 5'd0;
        do_mtc0(5'd13, 32'd0);
        mfc0_check("mfc0_cause_clr", 5'd13, 32'd0);

        // syscall entry
        Syscall = 1'b1; commit_pc(32'h100);
        check_eq("sys_redirect", {31'd0, Redirect}, 32'd1);
        check_eq("sys_rpc", Redirect_pc, 32'h0000F000);
        check_eq("sys_stall", {31'd0, Stall}, 32'd1);
        check_eq("sys_epc", EPC, 32'h100);
        check_eq("sys_cause", Cause, 32'h20);
        check_eq("sys_status", Status, 32'd0);
        tick();
        check_eq("sys_redirect_off", {31'd0, Redirect}, 32'd0);
        check_eq("sys_rpc_off", Redirect_pc, 32'd0);
        check_eq("sys_stall_off", {31'd0, Stall}, 32'd0);

        // priority: reserved instruction beats break and overflow
        Reserved_instruction = 1'b1; Break = 1'b1; Overflow = 1'b1;
        commit_pc(32'h104);
        check_eq("prio_cause", Cause, 32'h28);
        check_eq("prio_redirect", {31'd0, Redirect}, 32'd1);
        Commit = 1'b1; Syscall = 1'b1; PC_plus_4 = 32'h108;
        tick();
        clear_inputs();
        check_eq("enter_ignores_commit", {31'd0, Redirect}, 32'd0);
        check_eq("enter_cause_kept", Cause, 32'h28);
        check_eq("enter_epc_kept", EPC, 32'h104);

        // interrupt path through the synchronizer
        do_mtc0(5'd12, 32'h00000401);
        mfc0_check("mfc0_status", 5'd12, 32'h00000401);
        Interrupt_in = 6'b000001;
        tick();
        check_eq("sync_edge1", Cause, 32'h28);
        tick();
        check_eq("sync_edge2", Cause, 32'h428);
        commit_pc(32'h204);
        check_eq("int_redirect", {31'd0, Redirect}, 32'd1);
        check_eq("int_rpc", Redirect_pc, 32'h0000F000);
        check_eq("int_cause", Cause, 32'h400);
        check_eq("int_epc", EPC, 32'h204);
        check_eq("int_status", Status, 32'h400);
        tick();
        commit_pc(32'h208);
        check_eq("int_ie0_noredirect", {31'd0, Redirect}, 32'd0);
        check_eq("int_ie0_epc", EPC, 32'h204);
        do_mtc0(5'd12, 32'h00000001);
        commit_pc(32'h20C);
        check_eq("int_masked_noredirect", {31'd0, Redirect}, 32'd0);
        do_mtc0(5'd12, 32'h00000401);
        check_eq("int_mtc0_same_noredirect", {31'd0, Redirect}, 32'd0);
        commit_pc(32'h210);
        check_eq("int_next_redirect", {31'd0, Redirect}, 32'd1);
        check_eq("int_next_epc", EPC, 32'h210);
        tick();
        Interrupt_in = 6'd0;
        tick();
        tick();

        // eret returns to EPC
        do_mtc0(5'd14, 32'h300);
        Eret = 1'b1; commit_pc(32'h220);
        check_eq("eret_status", Status, 32'h401);
        check_eq("eret_redirect", {31'd0, Redirect}, 32'd1);
        check_eq("eret_rpc", Redirect_pc, 32'h300);
        check_eq("eret_stall", {31'd0, Stall}, 32'd1);
        tick();
        check_eq("eret_redirect_off", {31'd0, Redirect}, 32'd0);

        // syscall outranks eret in the same cycle
        Eret = 1'b1; Syscall = 1'b1; commit_pc(32'h400);
        check_eq("eret_sys_rpc", Redirect_pc, 32'h0000F000);
        check_eq("eret_sys_status", Status, 32'h400);
        check_eq("eret_sys_epc", EPC, 32'h400);
        check_eq("eret_sys_cause", Cause, 32'h20);
        tick();

        // reset during ENTER
        Break = 1'b1; commit_pc(32'h500);
        check_eq("rst_enter_pre", {31'd0, Redirect}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_enter_redirect", {31'd0, Redirect}, 32'd0);
        check_eq("rst_enter_stall", {31'd0, Stall}, 32'd0);
        check_eq("rst_enter_rpc", Redirect_pc, 32'd0);
        check_eq("rst_enter_status", Status, 32'd0);
        check_eq("rst_enter_cause", Cause, 32'd0);
        check_eq("rst_enter_epc", EPC, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_enter_after", {31'd0, Redirect}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_exception_controller.md
# cp0_exception_controller

Sequencer for the CP0 exception/interrupt path beside the decode stage. It owns the Status, Cause and EPC registers and samples the decode-stage exception flags and external interrupt lines. It arbitrates simultaneous events by fixed priority and runs a small state machine that stalls fetch, updates CP0 and issues a one-cycle PC redirect to the handler, or to EPC on `eret`. It also services `mtc0`/`mfc0` accesses to registers 12/13/14.

## Interface

**Parameters**
- `HANDLER_ADDR`, default 32'h0000F000: exception/interrupt handler entry PC.
- `INT_LINES`, default 6: number of external interrupt lines, mapped to Cause/Status bits [15:10].

**Ports**
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Commit` in 1: decode-stage instruction retires this cycle. All instruction-side inputs are ignored when 0.
- `PC_plus_4` in 32: PC+4 of the committing instruction.
- `Break`, `Syscall`, `Overflow`, `Divide_zero`, `Reserved_instruction` in 1 each: synchronous exception flags.
- `Eret` in 1: exception return.
- `Mtc0`, `Mfc0` in 1 each: CP0 move strobes.
- `Cp0_reg` in 5: CP0 register number (rd field).
- `Mtc0_data` in 32: write data (rt value).
- `Interrupt_in` in INT_LINES: asynchronous external interrupt requests, level-sensitive.
- `Cp0_read_data` out 32: `mfc0` result, combinational.
- `Redirect` out 1: PC override valid, one-cycle pulse.
- `Redirect_pc` out 32: override target.
- `Stall` out 1: hold fetch/decode.
- `Status`, `Cause`, `EPC` out 32 each: current CP0 register contents.

## Operation

**Register fields**
- Status[0]=IE; Status[15:8]=IM; all other Status bits are RW storage.
- Cause[6:2]=ExcCode; Cause[15:10]=IP_hw, read-only, fed by synchronized `Interrupt_in`; Cause[9:8]=IP_sw, software-writable; all other Cause bits read 0.

**Interrupt synchronization**
- `Interrupt_in` passes through a 2-flop synchronizer.
- Pending interrupt: `int_req = IE & |(Cause[15:8] & Status[15:8])`.

**Event priority** (evaluated only in IDLE with `Commit`=1; highest first)
- Reserved_instruction, ExcCode 10.
- Break, 9.
- Syscall, 8.
- Overflow, 12.
- Divide_zero, 7.
- Interrupt, 0.
- Eret.
- Mtc0.
- Synchronous exceptions are taken regardless of IE.

**FSM states:** IDLE, ENTER, RETURN.

**IDLE**
- Exception or interrupt: on the clock edge, EPC←`PC_plus_4`, Cause[6:2]←code, Status[0]←0; next state ENTER.
- Eret (no exception or interrupt): Status[0]←1; next state RETURN.
- Mtc0 (nothing above it): write `Mtc0_data` to reg 12 (all bits), 13 (bits [9:8] only) or 14 (all bits); other register numbers are ignored; stay in IDLE.
- Any lower-priority event in the same cycle is dropped.

**ENTER** (1 cycle)
- `Stall`=1, `Redirect`=1, `Redirect_pc`=HANDLER_ADDR.
- `Commit` is ignored; next state IDLE.

**RETURN** (1 cycle)
- `Stall`=1, `Redirect`=1, `Redirect_pc`=EPC (value held at the RETURN cycle).
- Next state IDLE.

**Mfc0**
- reg 12/13/14 returns Status/Cause/EPC.
- Any other register returns 32'hFFFFFFFF.
- `Mfc0`=0 returns 32'hFFFFFFFF.

## Timing

**Reset**
- State IDLE.
- Status, Cause, EPC = 0.
- Synchronizer flops = 0.
- `Redirect`=0, `Stall`=0, `Redirect_pc`=0.
- `Cp0_read_data`=32'hFFFFFFFF.

**Latency**
- Event committed in cycle T: CP0 updated at edge ending T; `Redirect`/`Stall` high for cycle T+1 only; IDLE again at T+2.
- External interrupt edge to recognition: 2 clock edges of synchronizer latency, plus a committing instruction.
- `Mtc0` write is visible to `Mfc0` in the next cycle.
- `Redirect_pc` = 0 whenever `Redirect`=0.

**Boundary cases**
- Eret with Syscall in the same cycle: Syscall wins; IE ends at 0.
- Interrupt pending while IE=0 or masked: no action; IP bits still update.
- Mtc0 to Status setting IE=1 with a pending interrupt: taken on the next committing instruction, not the same one.
- Reset asserted during ENTER/RETURN: immediate return to IDLE, outputs at reset values, no redirect.

## Test plan

1. Reset, then Syscall with `Commit`, PC_plus_4=0x100 → next cycle Redirect=1, Redirect_pc=0xF000, Stall=1; EPC=0x100, Cause[6:2]=8, Status[0]=0; cycle after, Redirect=0.
2. Reserved_instruction+Break+Overflow together → Cause[6:2]=10; only one redirect pulse.
3. Mtc0 reg 12 data 0x0000_0401, then Interrupt_in[0]=1 held, then `Commit` with PC_plus_4=0x204 → redirect to 0xF000 after the 2-edge sync; Cause[6:2]=0, EPC=0x204; with IM bit 10 cleared → no redirect.
4. Mtc0 reg 14 = 0x300, then Eret with `Commit` → Status[0]=1; next cycle Redirect_pc=0x300; with Syscall in the same cycle → redirect to 0xF000 instead.
5. Mtc0 reg 13 data 0xFFFFFFFF → Mfc0 reg 13 returns 0x00000300; Mfc0 reg 5 → 0xFFFFFFFF.
6. Assert reset in the ENTER cycle → Redirect drops immediately; all registers 0.
